// File: rtl/switch_output_allocator_pkg.sv
// Shared switch types: flit payload, allocator state, index-width helper.
package switch_output_allocator_pkg;

  localparam int unsigned FLIT_DEST_W = 4;
  localparam int unsigned FLIT_DATA_W = 12;
  localparam int unsigned FLIT_W      = FLIT_DEST_W + FLIT_DATA_W;

  // Flit as it travels through the switch datapath.
  typedef struct packed {
    logic [FLIT_DEST_W-1:0] dest;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  // Wormhole allocator state: arbitrating, or holding the link for one packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Width of an index into n requesters; never zero so single-bit vectors stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_output_allocator_rr_pick.sv
// Combinational round-robin first-set finder: scans mask from start upward, wrapping.
module switch_output_allocator_rr_pick
  import switch_output_allocator_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   index,
  output logic            found
);

  // Walk offsets from the far end back to start so the nearest set bit wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      int unsigned j;
      j = 32'(start) + k - 1;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (mask[IW'(j)]) begin
        index = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_output_allocator.sv
// Per-output wormhole allocator: round-robin grant, packet lock, credit metering.
module switch_output_allocator
  import switch_output_allocator_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned CREDITS = 8,
  localparam int unsigned CW      = $clog2(CREDITS + 1),
  localparam int unsigned IW      = idx_w(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  flit_t [NREQ-1:0]        req_flit,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_pop,
  output logic                    out_valid,
  output flit_t                   out_flit,
  output logic                    out_last,
  input  logic                    credit_return,
  output logic [IW-1:0]           grant_id,
  output logic                    busy,
  output logic [CW-1:0]           credits,
  output logic                    credit_err
);

  alloc_state_e   state;
  logic [IW-1:0]  start_c;
  logic [IW-1:0]  pick_idx_c;
  logic           pick_found_c;
  logic [IW-1:0]  sel_c;
  logic           have_c;
  logic           send_c;

  // Arbitration starts just past the current/last owner so it is eligible last.
  always_comb begin
    start_c = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
  end

  switch_output_allocator_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .mask  (req),
    .start (start_c),
    .index (pick_idx_c),
    .found (pick_found_c)
  );

  // Select the sender: round-robin winner when idle, the owner alone when locked.
  // Only registered credits gate the send, keeping credit_return off the pop path.
  always_comb begin
    sel_c  = grant_id;
    have_c = 1'b0;
    if (state == IDLE) begin
      sel_c  = pick_idx_c;
      have_c = pick_found_c;
    end else begin
      have_c = req[grant_id];
    end
    send_c  = have_c && (credits != '0);
    req_pop = send_c ? (NREQ'(1) << sel_c) : '0;
  end

  // Allocator FSM, output flit register and credit counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      grant_id   <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_last   <= 1'b0;
      credits    <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      out_valid <= send_c;
      if (send_c) begin
        out_flit <= req_flit[sel_c];
        out_last <= req_last[sel_c];
      end

      case (state)
        IDLE: begin
          if (send_c) begin
            grant_id <= sel_c;
            if (!req_last[sel_c]) begin
              state <= LOCKED;
              busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (send_c && req_last[grant_id]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      case ({send_c, credit_return})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CW'(CREDITS)) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + CW'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_output_allocator.sv
// Directed bench for switch_output_allocator with hand-computed expectations.
module tb_switch_output_allocator;
  import switch_output_allocator_pkg::*;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  flit_t [3:0] req_flit;
  logic [3:0]  req_last;
  logic [3:0]  req_pop;
  logic        out_valid;
  flit_t       out_flit;
  logic        out_last;
  logic        credit_return;
  logic [1:0]  grant_id;
  logic        busy;
  logic [3:0]  credits;
  logic        credit_err;

  int n_chk;
  int n_err;

  switch_output_allocator #(
    .NREQ    (4),
    .CREDITS (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req           (req),
    .req_flit      (req_flit),
    .req_last      (req_last),
    .req_pop       (req_pop),
    .out_valid     (out_valid),
    .out_flit      (out_flit),
    .out_last      (out_last),
    .credit_return (credit_return),
    .grant_id      (grant_id),
    .busy          (busy),
    .credits       (credits),
    .credit_err    (credit_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input int src, input int k);
    flit_t f;
    f.dest = 4'(src);
    f.data = 12'(k);
    return f;
  endfunction

  task automatic set_flits(input int k);
    for (int i = 0; i < 4; i++) req_flit[i] = mk(i, k);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RST = 1'b1;
    req = '0;
    req_last = '0;
    credit_return = 1'b0;
    set_flits(0);

    // Reset then idle
    tick;
    tick;
    RST = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", 32'(out_valid), 32'(0));
      chk("idle_credits", 32'(credits), 32'(8));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_grant", 32'(grant_id), 32'(0));
      chk("idle_pop", 32'(req_pop), 32'(0));
      tick;
    end

    // Round robin over single-flit packets with matching credit returns
    req = 4'b1111;
    req_last = 4'b1111;
    credit_return = 1'b1;
    for (int r = 0; r < 4; r++) begin
      set_flits(r + 1);
      #1;
      chk("rr_pop", 32'(req_pop), 32'(1 << ((r + 1) % 4)));
      tick;
      chk("rr_valid", 32'(out_valid), 32'(1));
      chk("rr_flit", {16'h0, out_flit}, {16'h0, mk((r + 1) % 4, r + 1)});
      chk("rr_last", 32'(out_last), 32'(1));
      chk("rr_grant", 32'(grant_id), 32'((r + 1) % 4));
      chk("rr_credits", 32'(credits), 32'(8));
    end
    req = '0;
    credit_return = 1'b0;
    tick;
    chk("rr_idle_valid", 32'(out_valid), 32'(0));

    // Wormhole lock: move owner to 1, then input 2 sends a 4-flit packet
    req = 4'b0010;
    req_last = 4'b0010;
    credit_return = 1'b1;
    set_flits(5);
    #1;
    chk("wh_pre_pop", 32'(req_pop), 32'(4'b0010));
    tick;
    chk("wh_pre_grant", 32'(grant_id), 32'(1));
    req = 4'b0111;
    for (int f = 0; f < 4; f++) begin
      if (f == 2) begin
        req = 4'b0011;
        credit_return = 1'b0;
        #1;
        chk("wh_bubble_pop", 32'(req_pop), 32'(0));
        tick;
        chk("wh_bubble_valid", 32'(out_valid), 32'(0));
        chk("wh_bubble_busy", 32'(busy), 32'(1));
        chk("wh_bubble_hold", {16'h0, out_flit}, {16'h0, mk(2, 11)});
        req = 4'b0111;
        credit_return = 1'b1;
      end
      req_last = (f == 3) ? 4'b0111 : 4'b0011;
      set_flits(10 + f);
      #1;
      chk("wh_pop", 32'(req_pop), 32'(4'b0100));
      tick;
      chk("wh_flit", {16'h0, out_flit}, {16'h0, mk(2, 10 + f)});
      chk("wh_busy", 32'(busy), 32'((f != 3) ? 1 : 0));
      chk("wh_last", 32'(out_last), 32'((f == 3) ? 1 : 0));
    end
    req = 4'b1011;
    req_last = 4'b1111;
    set_flits(20);
    #1;
    chk("wh_next_pop", 32'(req_pop), 32'(4'b1000));
    tick;
    chk("wh_next_flit", {16'h0, out_flit}, {16'h0, mk(3, 20)});
    chk("wh_next_grant", 32'(grant_id), 32'(3));
    req = 4'b0011;
    #1;
    chk("wh_wrap_pop", 32'(req_pop), 32'(4'b0001));
    tick;
    chk("wh_wrap_grant", 32'(grant_id), 32'(0));
    chk("wh_credits", 32'(credits), 32'(8));
    chk("wh_err", 32'(credit_err), 32'(0));
    req = '0;
    credit_return = 1'b0;

    // Credit stall: 12-flit packet from input 1 with only 8 credits
    req = 4'b0010;
    req_last = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      set_flits(30 + i);
      #1;
      chk("cs_pop", 32'(req_pop), 32'(4'b0010));
      tick;
      chk("cs_credits", 32'(credits), 32'(7 - i));
      chk("cs_flit", {16'h0, out_flit}, {16'h0, mk(1, 30 + i)});
    end
    #1;
    chk("cs_stall_pop", 32'(req_pop), 32'(0));
    tick;
    chk("cs_stall_valid", 32'(out_valid), 32'(0));
    chk("cs_stall_busy", 32'(busy), 32'(1));
    chk("cs_stall_credits", 32'(credits), 32'(0));
    chk("cs_stall_hold", {16'h0, out_flit}, {16'h0, mk(1, 37)});
    for (int j = 0; j < 4; j++) begin
      credit_return = 1'b1;
      #1;
      chk("cs_ret_pop", 32'(req_pop), 32'(0));
      tick;
      chk("cs_ret_credits", 32'(credits), 32'(1));
      credit_return = 1'b0;
      req_last = (j == 3) ? 4'b0010 : 4'b0000;
      set_flits(38 + j);
      #1;
      chk("cs_resume_pop", 32'(req_pop), 32'(4'b0010));
      tick;
      chk("cs_resume_credits", 32'(credits), 32'(0));
      chk("cs_resume_flit", {16'h0, out_flit}, {16'h0, mk(1, 38 + j)});
      chk("cs_resume_last", 32'(out_last), 32'((j == 3) ? 1 : 0));
    end
    req = '0;
    req_last = '0;
    chk("cs_done_busy", 32'(busy), 32'(0));

    // Simultaneous send and return at credits=1, then saturation
    credit_return = 1'b1;
    tick;
    chk("sr_credits1", 32'(credits), 32'(1));
    req = 4'b0100;
    req_last = 4'b0100;
    set_flits(45);
    #1;
    chk("sr_pop", 32'(req_pop), 32'(4'b0100));
    tick;
    chk("sr_valid", 32'(out_valid), 32'(1));
    chk("sr_credits", 32'(credits), 32'(1));
    chk("sr_err0", 32'(credit_err), 32'(0));
    req = '0;
    req_last = '0;
    for (int c = 0; c < 7; c++) tick;
    chk("sat_full", 32'(credits), 32'(8));
    chk("sat_err_pre", 32'(credit_err), 32'(0));
    tick;
    chk("sat_credits", 32'(credits), 32'(8));
    chk("sat_err", 32'(credit_err), 32'(1));
    credit_return = 1'b0;
    tick;
    tick;
    tick;
    chk("sat_err_sticky", 32'(credit_err), 32'(1));

    // Reset in the middle of a 5-flit packet from input 3
    req = 4'b1000;
    req_last = 4'b0000;
    set_flits(50);
    #1;
    chk("rm_pop", 32'(req_pop), 32'(4'b1000));
    tick;
    chk("rm_busy", 32'(busy), 32'(1));
    chk("rm_credits", 32'(credits), 32'(7));
    chk("rm_grant", 32'(grant_id), 32'(3));
    set_flits(51);
    RST = 1'b1;
    tick;
    chk("rm_rst_busy", 32'(busy), 32'(0));
    chk("rm_rst_valid", 32'(out_valid), 32'(0));
    chk("rm_rst_credits", 32'(credits), 32'(8));
    chk("rm_rst_grant", 32'(grant_id), 32'(0));
    chk("rm_rst_err", 32'(credit_err), 32'(0));
    chk("rm_rst_flit", {16'h0, out_flit}, 32'(0));
    RST = 1'b0;
    req = 4'b0011;
    req_last = 4'b0011;
    #1;
    chk("rm_restart_pop", 32'(req_pop), 32'(4'b0010));
    tick;
    chk("rm_restart_grant", 32'(grant_id), 32'(1));
    chk("rm_restart_busy", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
